// File: rtl/fifo_stream_drain_if.sv
// Signal bundle between the FIFO read port, the drain engine and the downstream stream consumer.
// master is the drain engine; slave is the FIFO/consumer side.
interface fifo_stream_drain_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic                 FIFO_EMPTY;
    logic                 FIFO_FULL;
    logic                 FIFO_WR_EN;
    logic [BUS_WIDTH-1:0] FIFO_DATA;
    logic                 FIFO_RD_EN;
    logic [BUS_WIDTH-1:0] M_DATA;
    logic                 M_VALID;
    logic                 M_LAST;
    logic                 M_READY;
    logic [15:0]          PKT_CNT;

    modport master (
        input  FIFO_EMPTY, FIFO_FULL, FIFO_WR_EN, FIFO_DATA, M_READY,
        output FIFO_RD_EN, M_DATA, M_VALID, M_LAST, PKT_CNT
    );

    modport slave (
        output FIFO_EMPTY, FIFO_FULL, FIFO_WR_EN, FIFO_DATA, M_READY,
        input  FIFO_RD_EN, M_DATA, M_VALID, M_LAST, PKT_CNT
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a one-cycle-latency FIFO read port into a 2-entry buffer and presents it as a
// valid/ready stream with a last-beat marker every PKT_LEN words.
module fifo_stream_drain #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned PKT_LEN   = 4
) (
    input logic                 CLK,
    input logic                 RSTn,
    fifo_stream_drain_if.master bus
);
    localparam int unsigned    BeatW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q;
    logic [BUS_WIDTH-1:0] head_q, head_d;
    logic [BUS_WIDTH-1:0] tail_q, tail_d;
    logic [BeatW-1:0]     beat_q;
    logic [15:0]          pkt_q;

    logic       m_valid;
    logic       m_last;
    logic       fire;
    logic       rd_en;
    logic       pop;
    logic [2:0] committed;

    always_comb begin
        m_valid   = (occ_q != 2'd0);
        m_last    = m_valid & (beat_q == LastBeat);
        fire      = m_valid & bus.M_READY;
        // Words held or in flight after this edge; fire implies occ >= 1, so no underflow.
        committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, fire};
        rd_en     = RSTn & ~bus.FIFO_EMPTY & (committed < 3'd2);
        pop       = rd_en & ~bus.FIFO_EMPTY & ~(bus.FIFO_WR_EN & ~bus.FIFO_FULL);
        occ_d     = committed[1:0];

        head_d = head_q;
        tail_d = tail_q;
        if (fire) begin
            head_d = tail_q;
            tail_d = '0;
        end
        if (inflight_q) begin
            // The arriving word lands in whichever slot is the tail after any fire.
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && fire)) begin
                head_d = bus.FIFO_DATA;
            end else begin
                tail_d = bus.FIFO_DATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
            pkt_q      <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= pop;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (fire) begin
                beat_q <= (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
                if (m_last) begin
                    pkt_q <= pkt_q + 16'd1;
                end
            end
        end
    end

    assign bus.FIFO_RD_EN = rd_en;
    assign bus.M_VALID    = m_valid;
    assign bus.M_DATA     = m_valid ? head_q : '0;
    assign bus.M_LAST     = m_last;
    assign bus.PKT_CNT    = pkt_q;
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a queue-based FIFO model feeds the DUT and the observed
// stream is compared with the pushed word order and PKT_LEN framing arithmetic.
module tb_fifo_stream_drain;
    localparam int Depth = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel;
    logic       empty, full, wr_en, ready;
    logic [7:0] fdata, wr_data;
    logic       rst0, rst1;

    assign rst0 = sel ? 1'b0 : rst;
    assign rst1 = sel ? rst : 1'b0;

    fifo_stream_drain_if #(.BUS_WIDTH(8)) bus0 ();
    fifo_stream_drain_if #(.BUS_WIDTH(8)) bus1 ();

    assign bus0.FIFO_EMPTY = empty;
    assign bus0.FIFO_FULL  = full;
    assign bus0.FIFO_WR_EN = wr_en;
    assign bus0.FIFO_DATA  = fdata;
    assign bus0.M_READY    = ready;
    assign bus1.FIFO_EMPTY = empty;
    assign bus1.FIFO_FULL  = full;
    assign bus1.FIFO_WR_EN = wr_en;
    assign bus1.FIFO_DATA  = fdata;
    assign bus1.M_READY    = ready;

    fifo_stream_drain #(.BUS_WIDTH(8), .PKT_LEN(4)) u_dut (
        .CLK  (clk),
        .RSTn (rst0),
        .bus  (bus0)
    );

    fifo_stream_drain #(.BUS_WIDTH(8), .PKT_LEN(1)) u_dut1 (
        .CLK  (clk),
        .RSTn (rst1),
        .bus  (bus1)
    );

    logic        rd_en, valid, last;
    logic [7:0]  m_data;
    logic [15:0] pkt;
    assign rd_en  = sel ? bus1.FIFO_RD_EN : bus0.FIFO_RD_EN;
    assign valid  = sel ? bus1.M_VALID    : bus0.M_VALID;
    assign last   = sel ? bus1.M_LAST     : bus0.M_LAST;
    assign m_data = sel ? bus1.M_DATA     : bus0.M_DATA;
    assign pkt    = sel ? bus1.PKT_CNT    : bus0.PKT_CNT;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    logic       last_q[$];
    int         fire_cyc[$];
    int         cyc, pops, fires, max_commit, hold_err;
    int         first_rd, first_pop, first_valid;
    logic       stalled_prev, prev_last;
    logic [7:0] prev_data;
    int         checks, errors;

    task automatic update_flags();
        empty = (fifo_q.size() == 0);
        full  = (fifo_q.size() >= Depth);
    endtask

    task automatic clear_rec();
        out_q.delete();
        last_q.delete();
        fire_cyc.delete();
        pops = 0; fires = 0; max_commit = 0; hold_err = 0;
        first_rd = -1; first_pop = -1; first_valid = -1;
        stalled_prev = 1'b0;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
        update_flags();
    endtask

    // One clock: observe at the falling edge, then advance the FIFO model after the rising edge.
    task automatic cycle();
        logic pop_s, fire_s;
        @(negedge clk);
        cyc++;
        pop_s  = rd_en & ~empty & ~(wr_en & ~full);
        fire_s = valid & ready;
        if (rst !== 1'b1) begin
            pops = 0; fires = 0; stalled_prev = 1'b0;
            pop_s = 1'b0;
        end else begin
            if (rd_en === 1'b1 && first_rd < 0) first_rd = cyc;
            if (pop_s === 1'b1 && first_pop < 0) first_pop = cyc;
            if (valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (stalled_prev && (valid !== 1'b1 || m_data !== prev_data || last !== prev_last))
                hold_err++;
            stalled_prev = (valid === 1'b1) && (ready === 1'b0);
            prev_data = m_data;
            prev_last = last;
            if (fire_s === 1'b1) begin
                out_q.push_back(m_data);
                last_q.push_back(last);
                fire_cyc.push_back(cyc);
                fires++;
            end
            if (pop_s === 1'b1) pops++;
            if (pops - fires > max_commit) max_commit = pops - fires;
        end
        @(posedge clk);
        #1;
        if (pop_s === 1'b1) fdata = fifo_q.pop_front();
        if (wr_en && !full) begin
            fifo_q.push_back(wr_data);
            exp_q.push_back(wr_data);
        end
        update_flags();
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        update_flags();
        cycle();
        rst = 1'b1;
        clear_rec();
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b0; ready = 1'b1; wr_en = 1'b0;
        fifo_q.delete();
        load(8'h10, 8);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
            checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", m_data); end
            checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last); end
            checks++; if (pkt !== 16'd0) begin errors++; $display("FAIL reset_pkt got %0d exp 0", pkt); end
        end
    endtask

    task automatic test_streaming();
        do_reset();
        ready = 1'b1;
        load(8'h10, 8);
        run_until(8, 40);
        repeat (2) cycle();
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL stream_count got %0d exp 8", out_q.size()); end
        checks++;
        if (first_valid - first_rd != 2) begin
            errors++; $display("FAIL stream_latency got %0d exp 2", first_valid - first_rd);
        end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            checks++;
            if (out_q[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_q[i], 8'h10 + 8'(i));
            end
            checks++;
            if (last_q[i] !== ((i % 4) == 3)) begin
                errors++; $display("FAIL stream_last[%0d] got %b exp %b", i, last_q[i], (i % 4) == 3);
            end
        end
        if (fire_cyc.size() == 8) begin
            checks++;
            if (fire_cyc[7] - fire_cyc[0] != 7) begin
                errors++; $display("FAIL stream_span got %0d exp 7", fire_cyc[7] - fire_cyc[0]);
            end
        end
        checks++; if (pkt !== 16'd2) begin errors++; $display("FAIL stream_pkt got %0d exp 2", pkt); end
        checks++; if (valid !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL stream_idle got valid %b data %h exp 0 00", valid, m_data);
        end
    endtask

    task automatic test_backpressure();
        int pat[7] = '{1, 0, 0, 0, 1, 0, 1};
        int k = 0;
        do_reset();
        load(8'h10, 8);
        while (out_q.size() < 8 && k < 120) begin
            ready = pat[k % 7][0];
            cycle();
            k++;
        end
        ready = 1'b1;
        repeat (3) cycle();
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            checks++;
            if (out_q[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, out_q[i], 8'h10 + 8'(i));
            end
        end
        checks++; if (max_commit > 2) begin errors++; $display("FAIL bp_commit got %0d exp <=2", max_commit); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold got %0d exp 0", hold_err); end
        checks++; if (pkt !== 16'd2) begin errors++; $display("FAIL bp_pkt got %0d exp 2", pkt); end
    endtask

    task automatic test_collision();
        int n_a5 = 0;
        do_reset();
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        update_flags();
        ready = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
        cycle();
        wr_en = 1'b0;
        run_until(2, 30);
        repeat (2) cycle();
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL col_count got %0d exp 2", out_q.size()); end
        checks++;
        if (first_pop - first_rd != 1) begin
            errors++; $display("FAIL col_first_pop got %0d exp 1", first_pop - first_rd);
        end
        checks++;
        if (first_valid - first_pop != 2) begin
            errors++; $display("FAIL col_latency got %0d exp 2", first_valid - first_pop);
        end
        foreach (out_q[i]) if (out_q[i] === 8'hA5) n_a5++;
        checks++; if (n_a5 != 1) begin errors++; $display("FAIL col_a5_once got %0d exp 1", n_a5); end
        if (out_q.size() == 2) begin
            checks++; if (out_q[0] !== 8'hA5) begin errors++; $display("FAIL col_first got %h exp a5", out_q[0]); end
            checks++; if (out_q[1] !== 8'h5A) begin errors++; $display("FAIL col_second got %h exp 5a", out_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1;
        load(8'h30, 8);
        run_until(2, 20);
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL mid_pre got %0d exp 2", out_q.size()); end
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        update_flags();
        cycle();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", valid); end
        rst = 1'b1;
        clear_rec();
        load(8'h20, 4);
        run_until(4, 30);
        repeat (3) cycle();
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL mid_count got %0d exp 4", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            checks++;
            if (out_q[i] !== 8'h20 + 8'(i) || last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL mid_beat[%0d] got %h/%b exp %h/%b", i, out_q[i], last_q[i],
                         8'h20 + 8'(i), i == 3);
            end
        end
        checks++; if (pkt !== 16'd1) begin errors++; $display("FAIL mid_pkt got %0d exp 1", pkt); end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        update_flags();
        for (k = 0; k < 400; k++) begin
            ready   = ($urandom % 10) < 6;
            wr_en   = (k < 40) && (($urandom % 5) == 0);
            wr_data = 8'($urandom);
            cycle();
            if (k >= 40 && out_q.size() == exp_q.size()) break;
        end
        wr_en = 1'b0;
        ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i] || last_q[i] !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL rnd_beat[%0d] got %h/%b exp %h/%b", i, out_q[i], last_q[i],
                         exp_q[i], (i % 4) == 3);
            end
        end
        checks++;
        if (pkt !== 16'(exp_q.size() / 4)) begin
            errors++; $display("FAIL rnd_pkt got %0d exp %0d", pkt, exp_q.size() / 4);
        end
        checks++; if (max_commit > 2) begin errors++; $display("FAIL rnd_commit got %0d exp <=2", max_commit); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL rnd_hold got %0d exp 0", hold_err); end
    endtask

    task automatic test_pkt_len1();
        sel = 1'b1;
        do_reset();
        ready = 1'b1;
        load(8'h01, 3);
        run_until(3, 20);
        repeat (2) cycle();
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL p1_count got %0d exp 3", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 3; i++) begin
            checks++;
            if (out_q[i] !== 8'h01 + 8'(i) || last_q[i] !== 1'b1) begin
                errors++;
                $display("FAIL p1_beat[%0d] got %h/%b exp %h/1", i, out_q[i], last_q[i], 8'h01 + 8'(i));
            end
        end
        checks++; if (pkt !== 16'd3) begin errors++; $display("FAIL p1_pkt got %0d exp 3", pkt); end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; ready = 1'b0; wr_en = 1'b0;
        wr_data = 8'h00; fdata = 8'h00; cyc = 0;
        checks = 0; errors = 0;
        update_flags();
        clear_rec();
        test_reset();
        test_streaming();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        test_pkt_len1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
